// File: rtl/ddr_port_arbiter_if.sv
// Bundle between the per-stream requesters, the arbiter and ddr_ctrl's burst port.
// slave = arbiter view, master = requesters + ddr_ctrl view.
interface ddr_port_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 10
);
  logic                                  ddr_init_done;
  logic [NUM_PORTS-1:0]                  port_req;
  logic [NUM_PORTS-1:0]                  port_wr;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  port_addr;
  logic [NUM_PORTS-1:0][LEN_WIDTH-1:0]   port_len;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  port_wdata;
  logic [NUM_PORTS-1:0]                  port_grant;
  logic [NUM_PORTS-1:0]                  port_wdata_req;
  logic [NUM_PORTS-1:0]                  port_rdata_valid;
  logic [DATA_WIDTH-1:0]                 port_rdata;
  logic [NUM_PORTS-1:0]                  port_finish;
  logic                                  wr_burst_req;
  logic [ADDR_WIDTH-1:0]                 wr_burst_addr;
  logic [LEN_WIDTH-1:0]                  wr_burst_len;
  logic [DATA_WIDTH-1:0]                 wr_burst_data;
  logic                                  wr_burst_data_req;
  logic                                  wr_burst_finish;
  logic                                  rd_burst_req;
  logic [ADDR_WIDTH-1:0]                 rd_burst_addr;
  logic [LEN_WIDTH-1:0]                  rd_burst_len;
  logic                                  rd_burst_data_valid;
  logic [DATA_WIDTH-1:0]                 rd_burst_data;
  logic                                  rd_burst_finish;
  logic                                  timeout_err;

  modport slave (
    input  ddr_init_done, port_req, port_wr, port_addr, port_len, port_wdata,
           wr_burst_data_req, wr_burst_finish,
           rd_burst_data_valid, rd_burst_data, rd_burst_finish,
    output port_grant, port_wdata_req, port_rdata_valid, port_rdata, port_finish,
           wr_burst_req, wr_burst_addr, wr_burst_len, wr_burst_data,
           rd_burst_req, rd_burst_addr, rd_burst_len, timeout_err
  );

  modport master (
    output ddr_init_done, port_req, port_wr, port_addr, port_len, port_wdata,
           wr_burst_data_req, wr_burst_finish,
           rd_burst_data_valid, rd_burst_data, rd_burst_finish,
    input  port_grant, port_wdata_req, port_rdata_valid, port_rdata, port_finish,
           wr_burst_req, wr_burst_addr, wr_burst_len, wr_burst_data,
           rd_burst_req, rd_burst_addr, rd_burst_len, timeout_err
  );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter multiplexing NUM_PORTS burst requesters onto ddr_ctrl's
// single read/write burst interface; one burst in flight, with a sticky watchdog.
module ddr_port_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_WIDTH  = 25,
  parameter int DATA_WIDTH  = 256,
  parameter int LEN_WIDTH   = 10,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  ddr_port_arbiter_if.slave bus
);
  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_e;

  state_e                 state_q;
  logic [SEL_W-1:0]       sel_q, rr_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [NUM_PORTS-1:0]   grant_q, finish_q;
  logic                   wreq_q, rreq_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tmo_q;

  logic [2*NUM_PORTS-1:0] req2, req_sh;
  logic [NUM_PORTS-1:0]   req_rot;
  logic [SEL_W-1:0]       win;
  logic                   win_vld;
  logic                   busy;

  function automatic logic [NUM_PORTS-1:0] oh(input logic [SEL_W-1:0] i);
    oh    = '0;
    oh[i] = 1'b1;
  endfunction

  // Rotate requests so bit 0 is the port at rr; first set bit wins.
  assign req2    = {bus.port_req, bus.port_req};
  assign req_sh  = req2 >> rr_q;
  assign req_rot = req_sh[NUM_PORTS-1:0];

  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!win_vld && req_rot[k]) begin
        win_vld = 1'b1;
        win     = SEL_W'((int'(rr_q) + k) % NUM_PORTS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      grant_q  <= '0;
      finish_q <= '0;
      wreq_q   <= 1'b0;
      rreq_q   <= 1'b0;
    end else begin
      finish_q <= '0;
      case (state_q)
        IDLE: if (bus.ddr_init_done && win_vld) begin
          sel_q   <= win;
          addr_q  <= bus.port_addr[win];
          len_q   <= bus.port_len[win];
          grant_q <= oh(win);
          if (bus.port_len[win] == '0) begin
            state_q  <= DONE;
            finish_q <= oh(win);
          end else if (bus.port_wr[win]) begin
            state_q <= WR;
            wreq_q  <= 1'b1;
          end else begin
            state_q <= RD;
            rreq_q  <= 1'b1;
          end
        end
        WR: if (bus.wr_burst_finish) begin
          wreq_q   <= 1'b0;
          state_q  <= DONE;
          finish_q <= oh(sel_q);
        end
        RD: if (bus.rd_burst_finish) begin
          rreq_q   <= 1'b0;
          state_q  <= DONE;
          finish_q <= oh(sel_q);
        end
        DONE: begin
          // Bubble back through IDLE so the owner's stale req is dropped first.
          rr_q    <= (sel_q == SEL_W'(NUM_PORTS - 1)) ? '0 : sel_q + 1'b1;
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == WR) || (state_q == RD);

  always_comb begin
    cnt_d = '0;
    if (busy) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  // Flag raised together with the counter reaching TIMEOUT_CYC-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (busy && cnt_q >= CNT_MAX - 1'b1) tmo_q <= 1'b1;
    end
  end

  assign bus.port_grant       = grant_q;
  assign bus.port_finish      = finish_q;
  assign bus.wr_burst_req     = wreq_q;
  assign bus.wr_burst_addr    = addr_q;
  assign bus.wr_burst_len     = len_q;
  assign bus.rd_burst_req     = rreq_q;
  assign bus.rd_burst_addr    = addr_q;
  assign bus.rd_burst_len     = len_q;
  assign bus.wr_burst_data    = (state_q == WR) ? bus.port_wdata[sel_q] : '0;
  assign bus.port_wdata_req   = (state_q == WR && bus.wr_burst_data_req) ? oh(sel_q) : '0;
  assign bus.port_rdata_valid = (state_q == RD && bus.rd_burst_data_valid) ? oh(sel_q) : '0;
  assign bus.port_rdata       = bus.rd_burst_data;
  assign bus.timeout_err      = tmo_q;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Randomized bench for ddr_port_arbiter: requesters and a ddr_ctrl responder
// drive the DUT while a transaction-level model predicts every output each cycle.
module tb_ddr_port_arbiter;
  localparam int NP = 4, AW = 25, DW = 256, LW = 10, TMO = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ddr_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bif();
  ddr_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
                     .TIMEOUT_CYC(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  int n_chk = 0, n_fail = 0;
  // model: burst owner (-1 none), transfer phase, finish cycle, cycle index in burst
  int m_own = -1, m_rr = 0, m_cyc = 0, m_beats = 0, n_fin = 0;
  bit m_xfer = 0, m_fin = 0, m_wr = 0, m_tmo = 0;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  int fin_log[$];
  int cnt_wdreq[NP];
  bit auto_rr = 0, auto_rand = 0, noise = 1, hold_fin = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] ohv(input int p);
    ohv = (p >= 0) ? (256'd1 << p) : 256'd0;
  endfunction

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < DW / 32; i++) r = {r[DW-33:0], $urandom};
    return r;
  endfunction

  task automatic rq(input int p, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    bif.port_req[p]  = 1'b1;
    bif.port_wr[p]   = wr;
    bif.port_addr[p] = a;
    bif.port_len[p]  = l;
  endtask

  // One clock edge as seen by the specification's rules, using inputs held across it.
  task automatic model_edge();
    bit found = 0;
    if (m_fin) begin
      m_fin = 0;
      m_rr  = (m_own + 1) % NP;
      m_own = -1;
    end else if (m_own < 0) begin
      if (bif.ddr_init_done && bif.port_req != 0) begin
        for (int k = 0; k < NP; k++)
          if (!found && bif.port_req[(m_rr + k) % NP]) begin
            found = 1;
            m_own = (m_rr + k) % NP;
          end
        m_wr = bif.port_wr[m_own]; m_addr = bif.port_addr[m_own]; m_len = bif.port_len[m_own];
        if (m_len == 0) m_fin = 1;
        else begin m_xfer = 1; m_cyc = 1; m_beats = int'(m_len); end
      end
    end else if (m_xfer) begin
      m_cyc++;
      if (m_cyc >= TMO) m_tmo = 1;
      if (m_wr ? bif.wr_burst_finish : bif.rd_burst_finish) begin m_xfer = 0; m_fin = 1; end
    end
    if (m_fin) begin n_fin++; fin_log.push_back(m_own); end
  endtask

  task automatic check_regs();
    chk("grant", bif.port_grant, ohv(m_own));
    chk("finish", bif.port_finish, m_fin ? ohv(m_own) : 256'd0);
    chk("wr_req", bif.wr_burst_req, m_xfer && m_wr);
    chk("rd_req", bif.rd_burst_req, m_xfer && !m_wr);
    chk("timeout", bif.timeout_err, m_tmo);
    if (m_xfer && m_wr) begin
      chk("wr_addr", bif.wr_burst_addr, m_addr);
      chk("wr_len", bif.wr_burst_len, m_len);
    end else if (m_xfer) begin
      chk("rd_addr", bif.rd_burst_addr, m_addr);
      chk("rd_len", bif.rd_burst_len, m_len);
    end
  endtask

  task automatic gen_inputs();
    for (int p = 0; p < NP; p++) begin
      bif.port_wdata[p] = rnd256();
      if (bif.port_req[p] && m_fin && m_own == p) bif.port_req[p] = 1'b0;
      else if (!bif.port_req[p]) begin
        if (auto_rr) rq(p, 1'b0, AW'($urandom), LW'(192));
        else if (auto_rand && $urandom_range(3) == 0)
          rq(p, 1'($urandom_range(1)), AW'($urandom),
             ($urandom_range(3) == 0) ? LW'(0) : LW'($urandom_range(12, 1)));
      end else if (m_own == p && m_xfer && $urandom_range(3) == 0) begin
        bif.port_addr[p] = AW'($urandom);
        bif.port_len[p]  = LW'($urandom);
      end
    end
    bif.wr_burst_data_req = 0; bif.wr_burst_finish = 0;
    bif.rd_burst_data_valid = 0; bif.rd_burst_finish = 0;
    bif.rd_burst_data = rnd256();
    if (m_xfer) begin
      if (m_beats > 0) begin
        if ($urandom_range(3) != 0) begin
          m_beats--;
          if (m_wr) bif.wr_burst_data_req = 1; else bif.rd_burst_data_valid = 1;
        end
      end else if (!hold_fin) begin
        if (m_wr) bif.wr_burst_finish = 1; else bif.rd_burst_finish = 1;
      end
    end
    if (noise) begin
      if (!(m_xfer && m_wr)) begin
        bif.wr_burst_data_req = ($urandom_range(7) == 0);
        bif.wr_burst_finish   = ($urandom_range(7) == 0);
      end
      if (!(m_xfer && !m_wr)) begin
        bif.rd_burst_data_valid = ($urandom_range(7) == 0);
        bif.rd_burst_finish     = ($urandom_range(7) == 0);
      end
    end
    if (auto_rand && $urandom_range(63) == 0) bif.ddr_init_done = ~bif.ddr_init_done;
  endtask

  task automatic check_comb();
    chk("wdata_req", bif.port_wdata_req,
        (m_xfer && m_wr && bif.wr_burst_data_req) ? ohv(m_own) : 256'd0);
    chk("rdata_vld", bif.port_rdata_valid,
        (m_xfer && !m_wr && bif.rd_burst_data_valid) ? ohv(m_own) : 256'd0);
    chk("rdata", bif.port_rdata, bif.rd_burst_data);
    if (m_xfer && m_wr) chk("wr_data", bif.wr_burst_data, bif.port_wdata[m_own]);
    for (int p = 0; p < NP; p++) if (bif.port_wdata_req[p]) cnt_wdreq[p]++;
  endtask

  task automatic step();
    @(negedge clk);
    model_edge();
    check_regs();
    gen_inputs();
    #1;
    check_comb();
  endtask

  task automatic wait_quiet(input int maxc);
    int n = 0;
    while ((bif.port_req != 0 || m_own >= 0) && n < maxc) begin step(); n++; end
    chk("quiet_bound", (bif.port_req == 0 && m_own < 0), 1);
  endtask

  task automatic zero_inputs();
    bif.port_req = '0; bif.port_wr = '0; bif.port_addr = '0; bif.port_len = '0;
    bif.port_wdata = '0; bif.wr_burst_data_req = 0; bif.wr_burst_finish = 0;
    bif.rd_burst_data_valid = 0; bif.rd_burst_data = '0; bif.rd_burst_finish = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_grant"}, bif.port_grant, 0);
    chk({tag, "_finish"}, bif.port_finish, 0);
    chk({tag, "_wdreq"}, bif.port_wdata_req, 0);
    chk({tag, "_rvld"}, bif.port_rdata_valid, 0);
    chk({tag, "_wreq"}, bif.wr_burst_req, 0);
    chk({tag, "_rreq"}, bif.rd_burst_req, 0);
    chk({tag, "_waddr"}, bif.wr_burst_addr, 0);
    chk({tag, "_wlen"}, bif.wr_burst_len, 0);
    chk({tag, "_wdata"}, bif.wr_burst_data, 0);
    chk({tag, "_tmo"}, bif.timeout_err, 0);
  endtask

  initial begin
    int n;
    zero_inputs();
    bif.ddr_init_done = 0;
    for (int p = 0; p < NP; p++) cnt_wdreq[p] = 0;
    #1 rst_n = 1'b0;
    #1 chk_reset_outs("rst");
    #20 rst_n = 1'b1;
    bif.ddr_init_done = 1;

    // all ports stream reads; rr starts at 0
    auto_rr = 1;
    n = 0;
    while (n_fin < 5 && n < 3000) begin step(); n++; end
    chk("rr_bound", n_fin >= 5, 1);
    auto_rr = 0;
    wait_quiet(3000);
    for (int i = 0; i < 5; i++) chk("rr_order", fin_log[i], i % NP);

    // single write from port1
    fin_log.delete();
    for (int p = 0; p < NP; p++) cnt_wdreq[p] = 0;
    rq(1, 1'b1, AW'('h40000), LW'(64));
    wait_quiet(500);
    chk("wdreq_cnt", cnt_wdreq[1], 64);
    chk("wr_owner", fin_log[0], 1);

    // rr now 2: port2 read beats port0 write
    rq(0, 1'b1, AW'($urandom), LW'(64));
    rq(2, 1'b0, AW'($urandom), LW'(192));
    wait_quiet(1500);
    chk("mixed_first", fin_log[1], 2);
    chk("mixed_second", fin_log[2], 0);

    // init gating then zero-length burst
    bif.ddr_init_done = 0;
    rq(3, 1'b0, AW'($urandom), LW'(8));
    repeat (100) step();
    chk("gate_grant", bif.port_grant, 0);
    bif.port_len[3] = '0;
    bif.ddr_init_done = 1;
    wait_quiet(20);
    chk("zero_len_owner", fin_log[3], 3);

    // random traffic
    auto_rand = 1;
    repeat (3000) step();
    auto_rand = 0;
    bif.ddr_init_done = 1;
    wait_quiet(2000);

    // watchdog: finish withheld past TIMEOUT_CYC, then released
    hold_fin = 1;
    rq(0, 1'b0, AW'($urandom), LW'(4));
    n = 0;
    while (!(m_xfer && m_cyc >= TMO + 8) && n < TMO + 200) begin step(); n++; end
    chk("tmo_set", bif.timeout_err, 1);
    hold_fin = 0;
    wait_quiet(100);
    chk("tmo_sticky", bif.timeout_err, 1);

    // reset in the middle of a write burst
    rq(2, 1'b1, AW'($urandom), LW'(64));
    n = 0;
    while (!(m_xfer && m_cyc >= 20) && n < 200) begin step(); n++; end
    chk("midrst_active", bif.wr_burst_req, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("midrst");
    zero_inputs();
    m_own = -1; m_xfer = 0; m_fin = 0; m_rr = 0; m_tmo = 0; m_beats = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    fin_log.delete();
    for (int p = 0; p < NP; p++) rq(p, 1'b0, AW'($urandom), LW'(3));
    wait_quiet(500);
    chk("post_rst_first", fin_log[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
